traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/tlm_pkg.sv | 34 +++
 rtl/tlm_decode.sv | 33 +++
 rtl/traffic_light_monitor.sv | 158 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
// rtl/tlm_pkg.sv - shared lamp codes, direction, fault code and state types
package tlm_pkg;

    localparam logic [1:0] LAMP_GREEN = 2'b01;
    localparam logic [1:0] LAMP_RED   = 2'b10;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_W = 2'd1,
        DIR_S = 2'd2,
        DIR_N = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ILLEGAL  = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_DURATION = 3'd4,
        FC_STALL    = 3'd5
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Rotation order is E -> W -> S -> N -> E.
    function automatic logic [1:0] next_dir(input logic [1:0] dir);
        return dir + 2'd1;
    endfunction

endpackage

// File: rtl/tlm_decode.sv
// rtl/tlm_decode.sv - combinational decode of the four lamp codes
module tlm_decode
    import tlm_pkg::*;
(
    input  logic [1:0] light_e,
    input  logic [1:0] light_w,
    input  logic [1:0] light_s,
    input  logic [1:0] light_n,
    output logic       illegal,
    output logic [2:0] green_cnt,
    output logic [1:0] green_idx
);

    logic [7:0] lamps;

    assign lamps = {light_n, light_s, light_w, light_e};

    // Scan from N down to E so the lowest green index wins when several are lit.
    always_comb begin
        illegal   = 1'b0;
        green_cnt = 3'd0;
        green_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (lamps[2*i +: 2] == LAMP_GREEN) begin
                green_cnt = green_cnt + 3'd1;
                green_idx = 2'(i);
            end else if (lamps[2*i +: 2] != LAMP_RED) begin
                illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks a four-way signal controller's phase sequence and timing
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int GREEN_TICKS = 6,
    parameter int ALLRED_MAX  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] light_e,
    input  logic [1:0] light_w,
    input  logic [1:0] light_s,
    input  logic [1:0] light_n,
    input  logic       clr_fault,
    output logic       synced,
    output logic [1:0] active_dir,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] phase_cnt
);

    localparam logic [7:0] GREEN_LIM  = 8'(GREEN_TICKS);
    localparam logic [7:0] ALLRED_LIM = 8'(ALLRED_MAX);

    state_e      state;
    logic [7:0]  tick_cnt;
    logic [7:0]  stall_cnt;
    logic        red_gap;
    logic        sync_seen;
    logic [1:0]  sync_idx;

    logic        illegal;
    logic [2:0]  green_cnt;
    logic [1:0]  green_idx;

    logic        one_green;
    logic [7:0]  tick_nxt;
    logic [7:0]  stall_nxt;
    logic        phase_ok;
    fault_code_e det_code;

    tlm_decode u_decode (
        .light_e   (light_e),
        .light_w   (light_w),
        .light_s   (light_s),
        .light_n   (light_n),
        .illegal   (illegal),
        .green_cnt (green_cnt),
        .green_idx (green_idx)
    );

    // Priority chain encodes ILLEGAL > CONFLICT > SEQUENCE > DURATION > STALL.
    always_comb begin
        one_green = (green_cnt == 3'd1);
        tick_nxt  = (tick_cnt == 8'hff) ? tick_cnt : tick_cnt + 8'd1;
        stall_nxt = (stall_cnt == 8'hff) ? stall_cnt : stall_cnt + 8'd1;
        phase_ok  = 1'b0;
        det_code  = FC_NONE;
        if (illegal) begin
            det_code = FC_ILLEGAL;
        end else if (green_cnt > 3'd1) begin
            det_code = FC_CONFLICT;
        end else if (state == ST_TRACK) begin
            if (one_green && green_idx != active_dir) begin
                if (green_idx != next_dir(active_dir)) begin
                    det_code = FC_SEQUENCE;
                end else if (tick_cnt != GREEN_LIM) begin
                    det_code = FC_DURATION;
                end else begin
                    phase_ok = 1'b1;
                end
            end else if (one_green) begin
                if (red_gap) begin
                    det_code = FC_SEQUENCE;
                end else if (tick && tick_nxt > GREEN_LIM) begin
                    det_code = FC_DURATION;
                end
            end else if (tick && stall_nxt > ALLRED_LIM) begin
                det_code = FC_STALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SYNC;
            synced     <= 1'b0;
            active_dir <= DIR_E;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            phase_cnt  <= 8'd0;
            tick_cnt   <= 8'd0;
            stall_cnt  <= 8'd0;
            red_gap    <= 1'b0;
            sync_seen  <= 1'b0;
            sync_idx   <= 2'd0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (det_code != FC_NONE) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= det_code;
                        synced     <= 1'b0;
                    end else if (one_green) begin
                        if (sync_seen && green_idx != sync_idx) begin
                            state      <= ST_TRACK;
                            synced     <= 1'b1;
                            active_dir <= green_idx;
                            tick_cnt   <= 8'd0;
                            stall_cnt  <= 8'd0;
                            red_gap    <= 1'b0;
                        end else begin
                            sync_idx  <= green_idx;
                            sync_seen <= 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (det_code != FC_NONE) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= det_code;
                        synced     <= 1'b0;
                    end else if (phase_ok) begin
                        active_dir <= green_idx;
                        tick_cnt   <= 8'd0;
                        stall_cnt  <= 8'd0;
                        red_gap    <= 1'b0;
                        phase_cnt  <= phase_cnt + 8'd1;
                    end else if (one_green) begin
                        if (tick) tick_cnt <= tick_nxt;
                    end else begin
                        red_gap <= 1'b1;
                        if (tick) stall_cnt <= stall_nxt;
                    end
                end
                ST_FAULT: begin
                    // Resync from scratch: the last green seen before the fault is not trusted.
                    if (clr_fault) begin
                        state      <= ST_SYNC;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        tick_cnt   <= 8'd0;
                        stall_cnt  <= 8'd0;
                        red_gap    <= 1'b0;
                        sync_seen  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - table-driven scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam logic [1:0] G   = 2'b01;
    localparam logic [7:0] R8  = 8'hAA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] light_e = 2'b10;
    logic [1:0] light_w = 2'b10;
    logic [1:0] light_s = 2'b10;
    logic [1:0] light_n = 2'b10;
    logic       clr_fault = 1'b0;
    logic       synced;
    logic [1:0] active_dir;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] phase_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       clr;
        logic [7:0] lamps;
        logic       sy;
        logic [1:0] dir;
        logic       flt;
        logic [2:0] code;
        logic [7:0] ph;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    traffic_light_monitor #(.GREEN_TICKS(6), .ALLRED_MAX(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .light_e    (light_e),
        .light_w    (light_w),
        .light_s    (light_s),
        .light_n    (light_n),
        .clr_fault  (clr_fault),
        .synced     (synced),
        .active_dir (active_dir),
        .fault      (fault),
        .fault_code (fault_code),
        .phase_cnt  (phase_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gl(input int d);
        logic [7:0] l;
        l = R8;
        l[2*d +: 2] = G;
        return l;
    endfunction

    function automatic void add(input logic r, input logic t, input logic [7:0] l, input logic c,
                                input logic sy, input logic [1:0] d, input logic f,
                                input logic [2:0] fc, input logic [7:0] ph);
        vec_t v;
        v.rst = r; v.tick = t; v.clr = c; v.lamps = l;
        v.sy = sy; v.dir = d; v.flt = f; v.code = fc; v.ph = ph;
        tbl.push_back(v);
    endfunction

    function automatic void add_reset();
        add(1'b1, 1'b0, R8, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0);
    endfunction

    function automatic void add_ticks(input int n, input logic [7:0] l, input logic sy,
                                      input logic [1:0] d, input logic [7:0] ph);
        for (int k = 0; k < n; k++) add(1'b0, 1'b1, l, 1'b0, sy, d, 1'b0, 3'd0, ph);
    endfunction

    // E seen in SYNC, then W enters TRACK with active_dir=W.
    function automatic void add_sync_ew();
        add(1'b0, 1'b0, gl(0), 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, gl(1), 1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 8'd0);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [1:0] dir;
        logic [1:0] nd;

        // Normal rotation, ignored clr in TRACK, tolerated one-tick all-red gap, rst mid-phase
        add_reset();
        add(1'b0, 1'b0, gl(0), 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0);
        add_ticks(6, gl(0), 1'b0, 2'd0, 8'd0);
        add(1'b0, 1'b0, gl(1), 1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 8'd0);
        add_ticks(6, gl(1), 1'b1, 2'd1, 8'd0);
        add(1'b0, 1'b0, gl(2), 1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 8'd1);
        add_ticks(6, gl(2), 1'b1, 2'd2, 8'd1);
        add(1'b0, 1'b0, gl(3), 1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 8'd2);
        for (int k = 0; k < 6; k++) add(1'b0, 1'b1, gl(3), 1'b1, 1'b1, 2'd3, 1'b0, 3'd0, 8'd2);
        add(1'b0, 1'b1, R8, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 8'd2);
        add(1'b0, 1'b0, gl(0), 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 8'd3);
        add(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0);

        // Wrong next direction, held code in FAULT, clear, then fault+clr in same cycle
        add_reset();
        add_sync_ew();
        add_ticks(6, gl(1), 1'b1, 2'd1, 8'd0);
        add(1'b0, 1'b0, gl(3), 1'b0, 1'b0, 2'd1, 1'b1, 3'd3, 8'd0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b1, 3'd3, 8'd0);
        add(1'b0, 1'b0, R8, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, R8, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, gl(2), 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, gl(3), 1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, 8'h69, 1'b1, 1'b0, 2'd3, 1'b1, 3'd2, 8'd0);

        // Overlong green, clear, resync, then early change
        add_reset();
        add_sync_ew();
        add_ticks(6, gl(1), 1'b1, 2'd1, 8'd0);
        add(1'b0, 1'b1, gl(1), 1'b0, 1'b0, 2'd1, 1'b1, 3'd4, 8'd0);
        add(1'b0, 1'b0, gl(1), 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, gl(1), 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, gl(3), 1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 8'd0);
        add_ticks(5, gl(3), 1'b1, 2'd3, 8'd0);
        add(1'b0, 1'b0, gl(0), 1'b0, 1'b0, 2'd3, 1'b1, 3'd4, 8'd0);

        // ILLEGAL beats CONFLICT, CONFLICT in SYNC, SEQUENCE beats DURATION
        add_reset();
        add(1'b0, 1'b0, 8'hB5, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 8'd0);
        add_reset();
        add(1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 8'd0);
        add_reset();
        add_sync_ew();
        add_ticks(3, gl(1), 1'b1, 2'd1, 8'd0);
        add(1'b0, 1'b0, gl(0), 1'b0, 1'b0, 2'd1, 1'b1, 3'd3, 8'd0);

        // Stall, rst in FAULT, same direction returning after all-red
        add_reset();
        add_sync_ew();
        add_ticks(6, gl(1), 1'b1, 2'd1, 8'd0);
        add(1'b0, 1'b1, R8, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, R8, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b1, R8, 1'b0, 1'b0, 2'd1, 1'b1, 3'd5, 8'd0);
        add(1'b1, 1'b0, R8, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0);
        add_sync_ew();
        add(1'b0, 1'b0, R8, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 8'd0);
        add(1'b0, 1'b0, gl(1), 1'b0, 1'b0, 2'd1, 1'b1, 3'd3, 8'd0);

        // 256 valid changes: phase_cnt reaches 255 then wraps to 0
        add_reset();
        add_sync_ew();
        dir = 2'd1;
        for (int k = 1; k <= 256; k++) begin
            add_ticks(6, gl(int'(dir)), 1'b1, dir, 8'(k - 1));
            nd = dir + 2'd1;
            add(1'b0, 1'b0, gl(int'(nd)), 1'b0, 1'b1, nd, 1'b0, 3'd0, 8'(k));
            dir = nd;
        end

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            @(negedge clk);
            rst       = tbl[i].rst;
            tick      = tbl[i].tick;
            clr_fault = tbl[i].clr;
            {light_n, light_s, light_w, light_e} = tbl[i].lamps;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("synced",     i, {7'd0, synced},     {7'd0, e.sy});
            chk("active_dir", i, {6'd0, active_dir}, {6'd0, e.dir});
            chk("fault",      i, {7'd0, fault},      {7'd0, e.flt});
            chk("fault_code", i, {5'd0, fault_code}, {5'd0, e.code});
            chk("phase_cnt",  i, phase_cnt,          e.ph);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
